// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, frame constants and the baud divider helper.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        IDLE_LEVEL = 1'b1;

  // Whole clocks per bit cell; the remainder of the division is dropped.
  function automatic int unsigned clocks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_transmitter_byte_fifo.sv
// byte_fifo: synchronous FIFO with registered count and pointer wrap modulo DEPTH.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   i_push/i_data  write request and data (ignored when full)
//   i_pop/o_data   read request (ignored when empty) and head-of-queue data
//   o_empty        no entries stored
//   o_full_next    queue will be full after this cycle's push/pop
//   o_count        number of stored entries (one bit wider than the pointers)
module byte_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full_next,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [CW-1:0]    w_count_next;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign w_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !w_full;
  assign w_pop   = i_pop && !o_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - 1'b1;
    end
  end

  assign o_full_next = (w_count_next == CW'(DEPTH));
  assign o_count     = r_count;
  assign o_data      = r_mem[r_rd_ptr];

  // Storage array carries no reset; validity is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= w_count_next;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: queues bytes from a valid/ready port and sends them as 8N1 (or 8N2) frames,
// LSB first, back-to-back with no idle gap while the queue holds data.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   input_data     byte to send; accepted when input_valid && input_ready
//   input_ready    registered !full of the queue, low while in reset
//   uart_transmit  registered serial line, idle high
//   busy           frame on the wire or queue non-empty
//   fifo_count     bytes queued, excluding the byte being shifted out
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
  parameter int unsigned BAUD_RATE       = 115_200,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned STOP_BITS       = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    input_data,
  input  logic                          input_valid,
  output logic                          input_ready,
  output logic                          uart_transmit,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned CPB         = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int unsigned STOP_CYCLES = STOP_BITS * CPB;
  localparam int unsigned BAUD_W      = $clog2(STOP_CYCLES);
  localparam int unsigned BIT_W       = $clog2(DATA_BITS);

  tx_state_t             r_state;
  logic [BAUD_W-1:0]     r_baud;
  logic [BIT_W-1:0]      r_bit;
  logic [DATA_BITS-1:0]  r_shift;
  logic                  r_tx;
  logic                  r_ready;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic                  w_full_next;
  logic [7:0]            w_head;
  logic                  w_cell_end;
  logic                  w_stop_end;

  assign w_push     = input_valid && r_ready;
  assign w_cell_end = (r_baud == BAUD_W'(CPB - 1));
  assign w_stop_end = (r_baud == BAUD_W'(STOP_CYCLES - 1));
  // Pop from IDLE, or on the last stop cycle so the next START follows with no gap.
  assign w_pop      = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_stop_end));

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (w_push),
    .i_data      (input_data),
    .i_pop       (w_pop),
    .o_data      (w_head),
    .o_empty     (w_empty),
    .o_full_next (w_full_next),
    .o_count     (fifo_count)
  );

  // Ready is registered from the queue occupancy it will have next cycle.
  always_ff @(posedge clock) begin
    if (reset) r_ready <= 1'b0;
    else       r_ready <= !w_full_next;
  end

  // Frame FSM with baud counter, bit index and shift register; line level registered on each transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= IDLE_LEVEL;
    end else begin
      case (r_state)
        IDLE: begin
          r_tx   <= IDLE_LEVEL;
          r_baud <= '0;
          if (w_pop) begin
            r_shift <= w_head;
            r_state <= START;
            r_tx    <= 1'b0;
          end
        end
        START: begin
          if (w_cell_end) begin
            r_baud  <= '0;
            r_bit   <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_cell_end) begin
            r_baud  <= '0;
            r_shift <= {1'b0, r_shift[DATA_BITS-1:1]};
            if (r_bit == BIT_W'(DATA_BITS - 1)) begin
              r_state <= STOP;
              r_tx    <= IDLE_LEVEL;
            end else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_stop_end) begin
            r_baud <= '0;
            if (w_pop) begin
              r_shift <= w_head;
              r_state <= START;
              r_tx    <= 1'b0;
            end else begin
              r_state <= IDLE;
              r_tx    <= IDLE_LEVEL;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= IDLE_LEVEL;
        end
      endcase
    end
  end

  assign uart_transmit = r_tx;
  assign input_ready   = r_ready;
  assign busy          = (r_state != IDLE) || !w_empty;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter at 10 clocks per bit, with a 1-stop-bit and a 2-stop-bit instance.
module tb_uart_transmitter;

  logic       clk;
  logic       rst;
  logic [7:0] din, din2;
  logic       vld, vld2;
  logic       rdy, rdy2;
  logic       tx, tx2;
  logic       bsy, bsy2;
  logic [4:0] cnt, cnt2;

  int tests = 0;
  int fails = 0;

  // Frames decoded from the 1-stop-bit line by the monitor below.
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic       ok_q[$];
  int         cyc = 0;

  uart_transmitter #(
    .CLOCK_FREQUENCY(100), .BAUD_RATE(10), .FIFO_DEPTH(16), .STOP_BITS(1)
  ) dut (
    .clock(clk), .reset(rst), .input_data(din), .input_valid(vld), .input_ready(rdy),
    .uart_transmit(tx), .busy(bsy), .fifo_count(cnt)
  );

  uart_transmitter #(
    .CLOCK_FREQUENCY(100), .BAUD_RATE(10), .FIFO_DEPTH(16), .STOP_BITS(2)
  ) dut2 (
    .clock(clk), .reset(rst), .input_data(din2), .input_valid(vld2), .input_ready(rdy2),
    .uart_transmit(tx2), .busy(bsy2), .fifo_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Mid-cell sampling decoder: start detected on a low line, cells sampled at offset 5 of 10.
  bit         m_in_frame = 1'b0;
  int         m_pos = 0;
  int         m_start = 0;
  bit         m_ok = 1'b1;
  logic [7:0] m_sh = '0;
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      m_in_frame = 1'b0;
    end else begin
      if (m_in_frame) begin
        m_pos++;
      end else if (tx === 1'b0) begin
        m_in_frame = 1'b1;
        m_pos      = 0;
        m_start    = cyc;
        m_ok       = 1'b1;
        m_sh       = '0;
      end
      if (m_in_frame) begin
        if (m_pos % 10 == 5) begin
          if (m_pos / 10 == 0) begin
            if (tx !== 1'b0) m_ok = 1'b0;
          end else if (m_pos / 10 <= 8) begin
            m_sh = {tx, m_sh[7:1]};
          end else begin
            if (tx !== 1'b1) m_ok = 1'b0;
          end
        end
        if (m_pos == 99) begin
          rx_q.push_back(m_sh);
          st_q.push_back(m_start);
          ok_q.push_back(m_ok);
          m_in_frame = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    @(posedge clk); #1 din = d; vld = 1'b1;
    @(posedge clk); #1 vld = 1'b0;
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int n = 0;
    while (rx_q.size() < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(rx_q.size() >= target), 32'd1);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] cells;  // [0]=start cell, [8:1]=data cells LSB first, [9]=stop cell
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] msg[15];
  int         base;
  int         acc;
  int         lows;
  logic       exp_bit;

  initial begin
    vecs[0] = '{8'h48, 10'b1010010000};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h01, 10'b1000000010};
    vecs[5] = '{8'h80, 10'b1100000000};
    msg = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h77, 8'h6F,
            8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A, 8'h00};

    rst = 1'b1; vld = 1'b0; din = '0; vld2 = 1'b0; din2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_ready", rdy, 0);
    check("rst_busy", bsy, 0);
    check("rst_count", cnt, 0);
    check("rst_tx2", tx2, 1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("ready_after_rst", rdy, 1);

    // Single-byte frames: latency and exact per-cycle waveform.
    foreach (vecs[v]) begin
      base = rx_q.size();
      push_byte(vecs[v].data);
      @(negedge clk);
      check($sformatf("v%0d_lat_hi", v), tx, 1);
      check($sformatf("v%0d_cnt1", v), cnt, 1);
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        exp_bit = vecs[v].cells[c / 10];
        check($sformatf("v%0d_cyc%0d", v, c), tx, exp_bit);
        if (c == 50) check($sformatf("v%0d_busy_mid", v), bsy, 1);
      end
      @(negedge clk);
      check($sformatf("v%0d_idle_tx", v), tx, 1);
      check($sformatf("v%0d_idle_busy", v), bsy, 0);
      wait_frames($sformatf("v%0d_frame", v), base + 1, 10);
      if (rx_q.size() > base) check($sformatf("v%0d_decode", v), rx_q[base], vecs[v].data);
    end

    // Fifteen bytes pushed in consecutive cycles: contiguous frames in order.
    base = rx_q.size();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1 din = msg[i]; vld = 1'b1;
    end
    @(posedge clk); #1 vld = 1'b0;
    wait_frames("burst_frames", base + 15, 1800);
    for (int i = 0; i < 15; i++) begin
      if (rx_q.size() > base + i) begin
        check($sformatf("burst_byte%0d", i), rx_q[base + i], msg[i]);
        check($sformatf("burst_ok%0d", i), ok_q[base + i], 1);
        if (i > 0) check($sformatf("burst_gap%0d", i), st_q[base + i] - st_q[base + i - 1], 100);
      end
    end
    repeat (5) @(negedge clk);

    // Valid held for 20 cycles: 17 bytes accepted, then backpressure.
    base = rx_q.size();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 din = 8'h10 + 8'(acc); vld = 1'b1;
      @(negedge clk);
      if (rdy) acc++;
    end
    @(posedge clk); #1 vld = 1'b0;
    check("full_accepted", acc, 17);
    @(negedge clk);
    check("full_ready", rdy, 0);
    check("full_count", cnt, 16);
    wait_frames("full_frames", base + 17, 2000);
    for (int i = 0; i < 17; i++) begin
      if (rx_q.size() > base + i) check($sformatf("full_byte%0d", i), rx_q[base + i], 8'h10 + 8'(i));
    end
    check("full_no_extra", rx_q.size(), base + 17);
    repeat (5) @(negedge clk);

    // Reset during data bit 3 with three bytes queued.
    base = rx_q.size();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 din = (i == 0) ? 8'hC3 : 8'(i * 17); vld = 1'b1;
    end
    @(posedge clk); #1 vld = 1'b0;
    @(negedge clk);
    check("rstmid_start", tx, 0);
    repeat (42) @(negedge clk);
    check("rstmid_bit3", tx, 0);
    check("rstmid_count", cnt, 3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rstmid_tx", tx, 1);
    check("rstmid_cnt", cnt, 0);
    check("rstmid_busy", bsy, 0);
    check("rstmid_ready", rdy, 0);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("rstmid_no_fall", lows, 0);
    check("rstmid_no_frame", rx_q.size(), base);
    check("rstmid_ready_back", rdy, 1);

    // Two stop bits: 0x00 then 0xFF back to back.
    @(posedge clk); #1 din2 = 8'h00; vld2 = 1'b1;
    @(posedge clk); #1 din2 = 8'hFF;
    @(posedge clk); #1 vld2 = 1'b0;
    for (int c = 0; c < 220; c++) begin
      @(negedge clk);
      exp_bit = !(c < 90 || (c >= 110 && c < 120));
      check($sformatf("stop2_cyc%0d", c), tx2, exp_bit);
    end
    @(negedge clk);
    check("stop2_idle_tx", tx2, 1);
    check("stop2_idle_busy", bsy2, 0);

    // Byte pushed during the stop cell starts right after that cell.
    base = rx_q.size();
    push_byte(8'h33);
    @(negedge clk);
    check("late_hi", tx, 1);
    @(negedge clk);
    check("late_fall", tx, 0);
    repeat (91) @(negedge clk);
    check("late_in_stop", tx, 1);
    check("late_empty", cnt, 0);
    push_byte(8'h55);
    wait_frames("late_frames", base + 2, 300);
    if (rx_q.size() >= base + 2) begin
      check("late_byte0", rx_q[base], 8'h33);
      check("late_byte1", rx_q[base + 1], 8'h55);
      check("late_gap", st_q[base + 1] - st_q[base], 100);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
